// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one pipelined divider among N
// requesters; a tag pipeline steers each result back to its owner.
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int LATENCY = WIDTH + 2,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_dividend,
  input  logic [N*WIDTH-1:0] req_divisor,
  output logic [N-1:0]       rsp_valid,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic               rsp_dbz,
  output logic               div_in_valid,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_out_valid,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  output logic               err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] id;
    logic          dbz;
  } tag_t;

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
  logic                  div_in_valid_q, div_in_valid_d;
  logic [WIDTH-1:0]      div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]      div_divisor_q, div_divisor_d;
  logic [IW-1:0]         issue_id_q, issue_id_d;
  tag_t [LATENCY-1:0]    tag_q, tag_d;
  logic [N-1:0]          rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_quotient_q, rsp_quotient_d;
  logic [WIDTH-1:0]      rsp_remainder_q, rsp_remainder_d;
  logic                  rsp_dbz_q, rsp_dbz_d;
  logic                  err_q, err_d;

  logic [N-1:0]          elig;
  logic [N-1:0]          gnt;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_any;
  tag_t                  tail;
  logic                  rsp_fire;
  logic                  mismatch;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < MAX_C);
    end
  end

  // Search from ptr+1 with wrap, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IW'(idx);
      end
    end
    if (gnt_any) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  assign tail     = tag_q[LATENCY-1];
  assign rsp_fire = tail.vld && div_out_valid;
  assign mismatch = tail.vld != div_out_valid;

  always_comb begin
    ptr_d          = ptr_q;
    div_in_valid_d = gnt_any;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    issue_id_d     = issue_id_q;
    if (gnt_any) begin
      ptr_d          = gnt_id;
      div_dividend_d = req_dividend[int'(gnt_id)*WIDTH +: WIDTH];
      div_divisor_d  = req_divisor[int'(gnt_id)*WIDTH +: WIDTH];
      issue_id_d     = gnt_id;
    end
  end

  // Stage 0 samples the issue registers, aligning the tail with out_valid.
  always_comb begin
    tag_d        = tag_q;
    tag_d[0].vld = div_in_valid_q;
    tag_d[0].id  = issue_id_q;
    tag_d[0].dbz = (div_divisor_q == '0);
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d     = '0;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dbz_d       = rsp_dbz_q;
    err_d           = err_q || mismatch;
    if (rsp_fire) begin
      rsp_valid_d[tail.id] = 1'b1;
      rsp_quotient_d       = div_quotient;
      rsp_remainder_d      = div_remainder;
      rsp_dbz_d            = tail.dbz;
    end
  end

  always_comb begin
    logic inc;
    logic dec;
    inc   = 1'b0;
    dec   = 1'b0;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      inc = gnt[i];
      dec = rsp_fire && (tail.id == IW'(i));
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + ONE_C;
      end else if (!inc && dec) begin
        cnt_d[i] = cnt_q[i] - ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= IW'(N - 1);
      cnt_q           <= '0;
      div_in_valid_q  <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      issue_id_q      <= '0;
      tag_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dbz_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      div_in_valid_q  <= div_in_valid_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      issue_id_q      <= issue_id_d;
      tag_q           <= tag_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dbz_q       <= rsp_dbz_d;
      err_q           <= err_d;
    end
  end

  assign req_ready     = gnt;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign div_in_valid  = div_in_valid_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign err           = err_q;

  a_ready_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(rsp_valid));

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: random and directed traffic against a queue-based
// model of grant order, outstanding limits and response timing.
module tb_div_arbiter;

  localparam int WIDTH   = 32;
  localparam int N       = 4;
  localparam int LATENCY = WIDTH + 2;
  localparam int MAX_OUT = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_dividend;
  logic [N*WIDTH-1:0] req_divisor;
  logic [N-1:0]       rsp_valid;
  logic [WIDTH-1:0]   rsp_quotient;
  logic [WIDTH-1:0]   rsp_remainder;
  logic               rsp_dbz;
  logic               div_in_valid;
  logic [WIDTH-1:0]   div_dividend;
  logic [WIDTH-1:0]   div_divisor;
  logic               div_out_valid;
  logic [WIDTH-1:0]   div_quotient;
  logic [WIDTH-1:0]   div_remainder;
  logic               err;

  logic [WIDTH-1:0]   op_a [N];
  logic [WIDTH-1:0]   op_b [N];
  logic               force_ov;

  div_arbiter #(
    .WIDTH(WIDTH), .N(N), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .div_in_valid(div_in_valid), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_out_valid(div_out_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*WIDTH +: WIDTH] = op_a[i];
      req_divisor[i*WIDTH +: WIDTH]  = op_b[i];
    end
  end

  // Stand-in divider: fixed LATENCY, zero divisor yields 0/0.
  logic [LATENCY-1:0] dv_p;
  logic [WIDTH-1:0]   dq_p [LATENCY];
  logic [WIDTH-1:0]   dr_p [LATENCY];

  always @(posedge clk) begin
    if (rst) begin
      dv_p <= '0;
    end else begin
      dv_p <= {dv_p[LATENCY-2:0], div_in_valid};
      dq_p[0] <= (div_divisor == 0) ? '0 : div_dividend / div_divisor;
      dr_p[0] <= (div_divisor == 0) ? '0 : div_dividend % div_divisor;
      for (int k = 1; k < LATENCY; k++) begin
        dq_p[k] <= dq_p[k-1];
        dr_p[k] <= dr_p[k-1];
      end
    end
  end

  assign div_out_valid = dv_p[LATENCY-1] | force_ov;
  assign div_quotient  = dq_p[LATENCY-1];
  assign div_remainder = dr_p[LATENCY-1];

  // Reference model state
  typedef struct {
    int             due;
    int             id;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic           dbz;
  } exp_t;

  exp_t             pend [$];
  int               cyc;
  int               m_ptr;
  int               m_out [N];
  int               m_win;
  logic             m_err;
  logic             m_prev_gnt;
  logic [WIDTH-1:0] m_prev_a, m_prev_b;

  logic [N-1:0]     exp_ready, exp_rsp;
  logic [WIDTH-1:0] exp_q, exp_r;
  logic             exp_dbz, exp_div_v, exp_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic model_clear();
    pend.delete();
    m_ptr      = N - 1;
    m_win      = -1;
    m_err      = 1'b0;
    m_prev_gnt = 1'b0;
    m_prev_a   = '0;
    m_prev_b   = '0;
    exp_q      = '0;
    exp_r      = '0;
    exp_dbz    = 1'b0;
    for (int i = 0; i < N; i++) m_out[i] = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    force_ov  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    model_clear();
  endtask

  // Expected outputs for the current cycle; delivering a response frees
  // a slot before this cycle's arbitration.
  task automatic eval();
    exp_t e;
    #1;
    exp_rsp = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      exp_rsp[e.id] = 1'b1;
      exp_q   = e.q;
      exp_r   = e.r;
      exp_dbz = e.dbz;
      m_out[e.id]--;
    end
    m_win = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (m_win < 0 && req_valid[idx] && m_out[idx] < MAX_OUT) m_win = idx;
    end
    exp_ready = '0;
    if (m_win >= 0) exp_ready[m_win] = 1'b1;
    exp_div_v = m_prev_gnt;
    exp_err   = m_err;
  endtask

  task automatic adv();
    exp_t e;
    if (m_win >= 0) begin
      e.due = cyc + LATENCY + 2;
      e.id  = m_win;
      e.dbz = (op_b[m_win] == 0);
      e.q   = e.dbz ? '0 : op_a[m_win] / op_b[m_win];
      e.r   = e.dbz ? '0 : op_a[m_win] % op_b[m_win];
      pend.push_back(e);
      m_out[m_win]++;
      m_ptr      = m_win;
      m_prev_gnt = 1'b1;
      m_prev_a   = op_a[m_win];
      m_prev_b   = op_b[m_win];
    end else begin
      m_prev_gnt = 1'b0;
    end
    if (force_ov && !(pend.size() > 0 && pend[0].due == cyc + 1)) m_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_ops(input int i);
    op_a[i] = $urandom;
    case ($urandom_range(0, 3))
      0:       op_b[i] = '0;
      1:       op_b[i] = $urandom;
      default: op_b[i] = WIDTH'($urandom_range(1, 300));
    endcase
  endtask

  task automatic test_reset();
    eval();
    n_checks++;
    if ({req_ready, rsp_valid, div_in_valid, err, rsp_dbz} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctl got rdy=%b rsp=%b div_v=%b err=%b dbz=%b required all 0",
               req_ready, rsp_valid, div_in_valid, err, rsp_dbz);
    end
    n_checks++;
    if ({rsp_quotient, rsp_remainder, div_dividend, div_divisor} !== '0) begin
      n_errors++;
      $display("FAIL reset_data got q=%h r=%h a=%h b=%h required 0",
               rsp_quotient, rsp_remainder, div_dividend, div_divisor);
    end
    adv();
  endtask

  task automatic test_single_op();
    int t_rsp;
    logic [WIDTH-1:0] gq, gr;
    logic gd;
    t_rsp = -1;
    gq = '0; gr = '0; gd = 1'b0;
    do_reset();
    op_a[2] = 100; op_b[2] = 7;
    req_valid = 4'b0100;
    for (int c = 0; c < 45; c++) begin
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, div_in_valid, err} !==
          {exp_ready, exp_rsp, exp_div_v, exp_err}) begin
        n_errors++;
        $display("FAIL single_ctl c=%0d got %b/%b/%b/%b required %b/%b/%b/%b", c,
                 req_ready, rsp_valid, div_in_valid, err,
                 exp_ready, exp_rsp, exp_div_v, exp_err);
      end
      if (exp_div_v) begin
        n_checks++;
        if ({div_dividend, div_divisor} !== {m_prev_a, m_prev_b}) begin
          n_errors++;
          $display("FAIL single_ops c=%0d got %h/%h required %h/%h", c,
                   div_dividend, div_divisor, m_prev_a, m_prev_b);
        end
      end
      if (c == 0) begin
        n_checks++;
        if (req_ready !== 4'b0100) begin
          n_errors++;
          $display("FAIL single_grant got %b required 0100", req_ready);
        end
      end
      if (c == 1) begin
        n_checks++;
        if ({div_in_valid, div_dividend, div_divisor} !== {1'b1, 32'd100, 32'd7}) begin
          n_errors++;
          $display("FAIL single_issue got v=%b %0d/%0d required 1 100/7",
                   div_in_valid, div_dividend, div_divisor);
        end
      end
      if (rsp_valid[2] && t_rsp < 0) begin
        t_rsp = c; gq = rsp_quotient; gr = rsp_remainder; gd = rsp_dbz;
      end
      adv();
      if (m_win >= 0) req_valid[m_win] = 1'b0;
    end
    n_checks++;
    if (t_rsp != 36 || gq !== 14 || gr !== 2 || gd !== 1'b0) begin
      n_errors++;
      $display("FAIL single_rsp got t=%0d q=%0d r=%0d dbz=%b required t=36 q=14 r=2 dbz=0",
               t_rsp, gq, gr, gd);
    end
  endtask

  task automatic test_round_robin();
    int ng;
    ng = 0;
    do_reset();
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = 4'hF;
    for (int c = 0; c < 110; c++) begin
      if (c == 60) req_valid = '0;
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL rr_ctl c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      if (exp_rsp != 0) begin
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_dbz} !== {exp_q, exp_r, exp_dbz}) begin
          n_errors++;
          $display("FAIL rr_data c=%0d got %h/%h/%b required %h/%h/%b", c,
                   rsp_quotient, rsp_remainder, rsp_dbz, exp_q, exp_r, exp_dbz);
        end
      end
      if (c < 16) begin
        if (req_ready != 0) ng++;
        n_checks++;
        if (req_ready !== N'(1 << (c % N))) begin
          n_errors++;
          $display("FAIL rr_order c=%0d got %b required %b", c, req_ready, N'(1 << (c % N)));
        end
      end
      adv();
      if (m_win >= 0) rand_ops(m_win);
    end
    n_checks++;
    if (ng != 16) begin
      n_errors++;
      $display("FAIL rr_count got %0d required 16", ng);
    end
  endtask

  task automatic test_max_out();
    int ng;
    ng = 0;
    do_reset();
    rand_ops(1);
    req_valid = 4'b0010;
    for (int c = 0; c < 95; c++) begin
      if (c == 50) req_valid = '0;
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL max_ctl c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      if (exp_rsp != 0) begin
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_dbz} !== {exp_q, exp_r, exp_dbz}) begin
          n_errors++;
          $display("FAIL max_data c=%0d got %h/%h/%b required %h/%h/%b", c,
                   rsp_quotient, rsp_remainder, rsp_dbz, exp_q, exp_r, exp_dbz);
        end
      end
      if (c < 36 && req_ready[1]) ng++;
      if (c == 36) begin
        n_checks++;
        if ({req_ready, rsp_valid} !== {4'b0010, 4'b0010}) begin
          n_errors++;
          $display("FAIL max_regrant got rdy=%b rsp=%b required 0010/0010",
                   req_ready, rsp_valid);
        end
      end
      adv();
      if (m_win >= 0) rand_ops(m_win);
    end
    n_checks++;
    if (ng != MAX_OUT) begin
      n_errors++;
      $display("FAIL max_count got %0d required %0d", ng, MAX_OUT);
    end
  endtask

  task automatic test_dbz();
    int ns, nr;
    logic [WIDTH*2:0] got [2];
    ns = 0; nr = 0;
    got[0] = '0; got[1] = '0;
    do_reset();
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'd0;
    req_valid = 4'b0001;
    for (int c = 0; c < 45; c++) begin
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL dbz_ctl c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      if (rsp_valid[0] && nr < 2) begin
        got[nr] = {rsp_quotient, rsp_remainder, rsp_dbz};
        nr++;
      end
      adv();
      if (m_win == 0) begin
        ns++;
        if (ns == 1) op_b[0] = 32'd1;
        else req_valid = '0;
      end
    end
    n_checks++;
    if (nr != 2 || got[0] !== {32'd0, 32'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL dbz_zero got n=%0d q/r/dbz=%h required 2 and 0/0/1", nr, got[0]);
    end
    n_checks++;
    if (got[1] !== {32'hFFFF_FFFF, 32'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL dbz_one got q/r/dbz=%h required ffffffff/0/0", got[1]);
    end
  endtask

  task automatic test_reset_mid();
    int ng;
    ng = 0;
    do_reset();
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL mid_pre c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      adv();
      if (m_win >= 0) req_valid[m_win] = 1'b0;
    end
    do_reset();
    for (int c = 0; c < 40; c++) begin
      eval();
      n_checks++;
      if ({rsp_valid, err} !== '0) begin
        n_errors++;
        $display("FAIL mid_quiet c=%0d got rsp=%b err=%b required 0/0", c, rsp_valid, err);
      end
      adv();
    end
    req_valid = 4'hF;
    eval();
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL mid_first got %b required 0001", req_ready);
    end
    adv();
    req_valid = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      if (c == 8) req_valid = '0;
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL mid_post c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      if (req_ready[2]) ng++;
      adv();
    end
    n_checks++;
    if (ng != MAX_OUT) begin
      n_errors++;
      $display("FAIL mid_cnt got %0d grants required %0d", ng, MAX_OUT);
    end
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int c = 0; c < 240; c++) begin
      if (c < 200) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            rand_ops(i);
          end
        end
      end
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, div_in_valid, err} !==
          {exp_ready, exp_rsp, exp_div_v, exp_err}) begin
        n_errors++;
        $display("FAIL rnd_ctl c=%0d got %b/%b/%b/%b required %b/%b/%b/%b", c,
                 req_ready, rsp_valid, div_in_valid, err,
                 exp_ready, exp_rsp, exp_div_v, exp_err);
      end
      if (exp_rsp != 0) begin
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_dbz} !== {exp_q, exp_r, exp_dbz}) begin
          n_errors++;
          $display("FAIL rnd_data c=%0d got %h/%h/%b required %h/%h/%b", c,
                   rsp_quotient, rsp_remainder, rsp_dbz, exp_q, exp_r, exp_dbz);
        end
      end
      if (exp_div_v) begin
        n_checks++;
        if ({div_dividend, div_divisor} !== {m_prev_a, m_prev_b}) begin
          n_errors++;
          $display("FAIL rnd_ops c=%0d got %h/%h required %h/%h", c,
                   div_dividend, div_divisor, m_prev_a, m_prev_b);
        end
      end
      adv();
      if (m_win >= 0) req_valid[m_win] = 1'b0;
    end
  endtask

  task automatic test_err();
    int ng;
    ng = 0;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      eval();
      adv();
    end
    force_ov = 1'b1;
    eval();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_early got %b required 0", err);
    end
    adv();
    force_ov = 1'b0;
    eval();
    n_checks++;
    if ({err, rsp_valid} !== {1'b1, 4'b0000}) begin
      n_errors++;
      $display("FAIL err_set got err=%b rsp=%b required 1/0000", err, rsp_valid);
    end
    adv();
    rand_ops(0);
    req_valid = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      if (c == 8) req_valid = '0;
      eval();
      n_checks++;
      if ({req_ready, rsp_valid, err} !== {exp_ready, exp_rsp, exp_err}) begin
        n_errors++;
        $display("FAIL err_after c=%0d got %b/%b/%b required %b/%b/%b", c,
                 req_ready, rsp_valid, err, exp_ready, exp_rsp, exp_err);
      end
      if (req_ready[0]) ng++;
      adv();
      if (m_win >= 0) rand_ops(m_win);
    end
    n_checks++;
    if (ng != MAX_OUT || err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky got grants=%0d err=%b required %0d/1", ng, err, MAX_OUT);
    end
  endtask

  initial begin
    req_valid = '0;
    force_ov  = 1'b0;
    cyc       = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    model_clear();
    do_reset();
    test_reset();
    test_single_op();
    test_round_robin();
    test_max_out();
    test_dbz();
    test_reset_mid();
    test_random_traffic();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
